// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the MEM/WB exception arbiter: CP0 exception codes,
// CP0 register addresses, Status/Cause field positions and mem_exc_i bit map.
package exc_ctrl_pkg;

    localparam logic [31:0] CODE_INT   = 32'h0000_0000;
    localparam logic [31:0] CODE_MOD   = 32'h0000_0001;
    localparam logic [31:0] CODE_TLBL  = 32'h0000_0002;
    localparam logic [31:0] CODE_TLBS  = 32'h0000_0003;
    localparam logic [31:0] CODE_ADEL  = 32'h0000_0004;
    localparam logic [31:0] CODE_ADES  = 32'h0000_0005;
    localparam logic [31:0] CODE_SYS   = 32'h0000_0008;
    localparam logic [31:0] CODE_RI    = 32'h0000_000a;
    localparam logic [31:0] CODE_CPU   = 32'h0000_000b;
    localparam logic [31:0] CODE_ERET  = 32'h0000_000e;
    localparam logic [31:0] CODE_WATCH = 32'h0000_0017;
    // Interrupt owns code 0, so the idle marker is all ones.
    localparam logic [31:0] CODE_NONE  = 32'hFFFF_FFFF;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_IM_LO = 8;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_IP_LO  = 8;

    localparam int EXC_W      = 10;
    localparam int EXC_ADEL   = 0;
    localparam int EXC_TLBL   = 1;
    localparam int EXC_TLBS   = 2;
    localparam int EXC_TLBMOD = 3;
    localparam int EXC_RI     = 4;
    localparam int EXC_CPU    = 5;
    localparam int EXC_SYS    = 6;
    localparam int EXC_ADES   = 7;
    localparam int EXC_WATCH  = 8;
    localparam int EXC_ERET   = 9;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority pick of one event from the pending interrupt and the MEM
// exception flags; lower-priority flags are simply dropped.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic             int_pend,
    input  logic [EXC_W-1:0] exc,
    output logic             hit,
    output logic [31:0]      code,
    output logic             is_eret
);

    always_comb begin
        hit     = 1'b1;
        code    = CODE_NONE;
        is_eret = 1'b0;
        if (int_pend)                code = CODE_INT;
        else if (exc[EXC_ADEL])      code = CODE_ADEL;
        else if (exc[EXC_TLBL])      code = CODE_TLBL;
        else if (exc[EXC_RI])        code = CODE_RI;
        else if (exc[EXC_CPU])       code = CODE_CPU;
        else if (exc[EXC_SYS])       code = CODE_SYS;
        else if (exc[EXC_ADES])      code = CODE_ADES;
        else if (exc[EXC_TLBS])      code = CODE_TLBS;
        else if (exc[EXC_TLBMOD])    code = CODE_MOD;
        else if (exc[EXC_WATCH])     code = CODE_WATCH;
        else if (exc[EXC_ERET]) begin
            code    = CODE_ERET;
            is_eret = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM/WB exception arbiter: forwards in-flight CP0 writes, selects one event,
// registers the CP0 request and holds flush until the pipeline has drained.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] EXC_OFFSET   = 32'h0000_0180,
    parameter logic [31:0] EXC_NONE     = CODE_NONE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid_i,
    input  logic [EXC_W-1:0] mem_exc_i,
    input  logic [31:0]      mem_pc_i,
    input  logic             mem_delayslot_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic [31:0]      cp0_ebase_i,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_wdata_i,
    output logic [31:0]      excepttype_o,
    output logic [31:0]      current_inst_addr_o,
    output logic             is_in_delayslot_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        eff_status, eff_cause, eff_epc;
    logic               int_pend;
    logic               hit, is_eret;
    logic [31:0]        code;
    logic [31:0]        vector_pc;
    logic [31:0]        type_nxt, addr_nxt, newpc_nxt;
    logic               ds_nxt, flush_nxt;
    logic               unused_bits;

    // A CP0 write still sitting in WB must be seen here, or an mtc0 that
    // masks interrupts or rewrites EPC would arrive one instruction late.
    always_comb begin
        eff_status = cp0_status_i;
        eff_cause  = cp0_cause_i;
        eff_epc    = cp0_epc_i;
        if (wb_cp0_we_i) begin
            case (wb_cp0_waddr_i)
                CP0_STATUS: eff_status = wb_cp0_wdata_i;
                CP0_CAUSE:  eff_cause[9:8] = wb_cp0_wdata_i[9:8];
                CP0_EPC:    eff_epc = wb_cp0_wdata_i;
                default:    ;
            endcase
        end
    end

    assign int_pend = eff_status[STATUS_IE] & ~eff_status[STATUS_EXL] &
                      (|(eff_cause[CAUSE_IP_HI:CAUSE_IP_LO] &
                         eff_status[STATUS_IM_HI:STATUS_IM_LO]));

    assign vector_pc = {cp0_ebase_i[31:12], 12'h000} + EXC_OFFSET;

    assign unused_bits = ^{eff_status[31:16], eff_status[7:2],
                           eff_cause[31:16], eff_cause[7:0], cp0_ebase_i[11:0]};

    exc_prio_enc u_prio_enc (
        .int_pend (int_pend),
        .exc      (mem_exc_i),
        .hit      (hit),
        .code     (code),
        .is_eret  (is_eret)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        type_nxt  = EXC_NONE;
        flush_nxt = 1'b0;
        addr_nxt  = current_inst_addr_o;
        ds_nxt    = is_in_delayslot_o;
        newpc_nxt = new_pc_o;
        case (state)
            ST_IDLE: begin
                if (mem_valid_i && hit) begin
                    type_nxt  = code;
                    addr_nxt  = mem_pc_i;
                    ds_nxt    = mem_delayslot_i;
                    flush_nxt = 1'b1;
                    newpc_nxt = is_eret ? eff_epc : vector_pc;
                    state_nxt = ST_FLUSH;
                    cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_FLUSH: begin
                // MEM is ignored here so a second event cannot re-enter mid-drain.
                if (cnt != '0) begin
                    cnt_nxt   = cnt - 1'b1;
                    flush_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            cnt                 <= '0;
            excepttype_o        <= EXC_NONE;
            current_inst_addr_o <= '0;
            is_in_delayslot_o   <= 1'b0;
            flush_o             <= 1'b0;
            new_pc_o            <= '0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            excepttype_o        <= type_nxt;
            current_inst_addr_o <= addr_nxt;
            is_in_delayslot_o   <= ds_nxt;
            flush_o             <= flush_nxt;
            new_pc_o            <= newpc_nxt;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: hand-computed vector table, multi-cycle
// sequences, and random traffic against a cycle-count reference model.
module tb_exc_ctrl;

    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [9:0]  mem_exc;
    logic [31:0] mem_pc;
    logic        mem_ds;
    logic [31:0] status, cause, epc, ebase;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [31:0] excepttype, inst_addr, new_pc;
    logic        in_ds, flush;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model outputs and drain countdown
    logic [31:0] m_type, m_addr, m_newpc;
    logic        m_ds, m_flush;
    int          m_remaining;

    int          prio_bit  [10] = '{0, 1, 4, 5, 6, 7, 2, 3, 8, 9};
    logic [31:0] prio_code [10] = '{32'h04, 32'h02, 32'h0a, 32'h0b, 32'h08,
                                    32'h05, 32'h03, 32'h01, 32'h17, 32'h0e};

    typedef struct {
        logic        valid;
        logic [9:0]  exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] ebase;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_type;
        logic        exp_flush;
        logic [31:0] exp_newpc;
        logic        exp_ds;
    } vec_t;

    vec_t vecs [16];

    exc_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid),
        .mem_exc_i           (mem_exc),
        .mem_pc_i            (mem_pc),
        .mem_delayslot_i     (mem_ds),
        .cp0_status_i        (status),
        .cp0_cause_i         (cause),
        .cp0_epc_i           (epc),
        .cp0_ebase_i         (ebase),
        .wb_cp0_we_i         (wb_we),
        .wb_cp0_waddr_i      (wb_waddr),
        .wb_cp0_wdata_i      (wb_wdata),
        .excepttype_o        (excepttype),
        .current_inst_addr_o (inst_addr),
        .is_in_delayslot_o   (in_ds),
        .flush_o             (flush),
        .new_pc_o            (new_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted event makes flush high for FLUSH_CYCLES cycles,
    // during which MEM is ignored; the cycle after that is free again.
    task automatic model_step();
        logic [31:0] st, ca, ep, code;
        logic        ip, found;
        if (rst) begin
            m_type = NONE; m_addr = 0; m_ds = 0; m_flush = 0; m_newpc = 0;
            m_remaining = 0;
            return;
        end
        m_type  = NONE;
        m_flush = 1'b0;
        if (m_remaining > 0) begin
            m_remaining--;
            m_flush = (m_remaining > 0);
            return;
        end
        if (!mem_valid) return;
        st = status; ca = cause; ep = epc;
        if (wb_we) begin
            if (wb_waddr == 5'd12) st = wb_wdata;
            if (wb_waddr == 5'd13) ca[9:8] = wb_wdata[9:8];
            if (wb_waddr == 5'd14) ep = wb_wdata;
        end
        ip = st[0] && !st[1] && ((ca[15:8] & st[15:8]) != 8'h00);
        found = 1'b0;
        code  = NONE;
        if (ip) begin
            found = 1'b1;
            code  = 32'h0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (!found && mem_exc[prio_bit[i]]) begin
                    found = 1'b1;
                    code  = prio_code[i];
                end
            end
        end
        if (found) begin
            m_type  = code;
            m_addr  = mem_pc;
            m_ds    = mem_ds;
            m_flush = 1'b1;
            m_newpc = (code == 32'h0e) ? ep : ({ebase[31:12], 12'h000} + 32'h180);
            m_remaining = FLUSH_CYCLES;
        end
    endtask

    task automatic checkOutput();
        chk("model excepttype", excepttype, m_type);
        chk("model flush", {31'b0, flush}, {31'b0, m_flush});
        chk("model new_pc", new_pc, m_newpc);
        chk("model inst_addr", inst_addr, m_addr);
        chk("model delayslot", {31'b0, in_ds}, {31'b0, m_ds});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input vec_t v);
        mem_valid = v.valid; mem_exc = v.exc; mem_pc = v.pc; mem_ds = v.ds;
        status = v.status; cause = v.cause; epc = v.epc; ebase = v.ebase;
        wb_we = v.we; wb_waddr = v.waddr; wb_wdata = v.wdata;
    endtask

    task automatic quiet();
        mem_valid = 0; mem_exc = 0; wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        status = 0; cause = 0;
    endtask

    task automatic drain();
        quiet();
        for (int i = 0; i < FLUSH_CYCLES + 1; i++) tick();
    endtask

    function automatic vec_t mk(logic valid, logic [9:0] exc, logic [31:0] pc, logic ds,
                                logic [31:0] st, logic [31:0] ca, logic [31:0] ep,
                                logic [31:0] eb, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [31:0] et, logic ef, logic [31:0] enp, logic eds);
        vec_t v;
        v.valid = valid; v.exc = exc; v.pc = pc; v.ds = ds; v.status = st; v.cause = ca;
        v.epc = ep; v.ebase = eb; v.we = we; v.waddr = wa; v.wdata = wd;
        v.exp_type = et; v.exp_flush = ef; v.exp_newpc = enp; v.exp_ds = eds;
        return v;
    endfunction

    task automatic syscall_in();
        quiet();
        mem_valid = 1; mem_exc = 10'h040; mem_pc = 32'h8000_1000; mem_ds = 0;
        ebase = 32'h8000_0000;
    endtask

    initial begin
        logic [31:0] addrs [4];
        addrs = '{32'd12, 32'd13, 32'd14, 32'd9};

        vecs[0]  = mk(1, 10'h040, 32'h8000_1000, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h08, 1, 32'h8000_0180, 0);
        vecs[1]  = mk(1, 10'h010, 32'h8000_2000, 1, 32'h401, 32'h400, 0, 32'h8000_0000, 0, 0, 0, 32'h00, 1, 32'h8000_0180, 1);
        vecs[2]  = mk(1, 10'h000, 32'h8000_2004, 0, 32'h403, 32'h400, 0, 32'h8000_0000, 0, 0, 0, NONE, 0, 32'h8000_0180, 1);
        vecs[3]  = mk(1, 10'h200, 32'h8000_3000, 0, 0, 0, 32'h1000, 32'h8000_0000, 1, 14, 32'h2000, 32'h0e, 1, 32'h2000, 0);
        vecs[4]  = mk(1, 10'h000, 32'h8000_3004, 0, 32'h401, 32'h400, 0, 32'h8000_0000, 1, 12, 0, NONE, 0, 32'h2000, 0);
        vecs[5]  = mk(0, 10'h000, 32'h8000_3008, 0, 32'h401, 32'h400, 0, 32'h8000_0000, 0, 0, 0, NONE, 0, 32'h2000, 0);
        vecs[6]  = mk(1, 10'h000, 32'h8000_4000, 0, 32'h101, 32'h000, 0, 32'h8000_0000, 1, 13, 32'h100, 32'h00, 1, 32'h8000_0180, 0);
        vecs[7]  = mk(1, 10'h005, 32'h8000_4004, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h04, 1, 32'h8000_0180, 0);
        vecs[8]  = mk(1, 10'h012, 32'h8000_4008, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h02, 1, 32'h8000_0180, 0);
        vecs[9]  = mk(1, 10'h060, 32'h8000_400c, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h0b, 1, 32'h8000_0180, 0);
        vecs[10] = mk(1, 10'h084, 32'h8000_4010, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h05, 1, 32'h8000_0180, 0);
        vecs[11] = mk(1, 10'h108, 32'h8000_4014, 0, 0, 0, 0, 32'h8000_0000, 0, 0, 0, 32'h01, 1, 32'h8000_0180, 0);
        vecs[12] = mk(1, 10'h300, 32'h8000_4018, 0, 0, 0, 32'h5555, 32'h8000_0000, 0, 0, 0, 32'h17, 1, 32'h8000_0180, 0);
        vecs[13] = mk(1, 10'h040, 32'h8000_401c, 0, 0, 0, 0, 32'hBFC0_0FFF, 0, 0, 0, 32'h08, 1, 32'hBFC0_0180, 0);
        vecs[14] = mk(1, 10'h000, 32'h8000_4020, 1, 32'h401, 32'h400, 0, 32'h8000_0000, 1, 13, 0, 32'h00, 1, 32'h8000_0180, 1);
        vecs[15] = mk(1, 10'h200, 32'h8000_4024, 0, 32'h0, 0, 32'h0000_7000, 32'h8000_0000, 0, 0, 0, 32'h0e, 1, 32'h0000_7000, 0);

        quiet();
        mem_pc = 0; mem_ds = 0; epc = 0; ebase = 0;
        rst = 1;
        tick();
        tick();
        chk("reset excepttype", excepttype, NONE);
        chk("reset flush", {31'b0, flush}, 32'd0);
        chk("reset new_pc", new_pc, 32'd0);
        chk("reset inst_addr", inst_addr, 32'd0);
        rst = 0;
        tick();

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
            tick();
            chk($sformatf("vec%0d excepttype", i), excepttype, vecs[i].exp_type);
            chk($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, vecs[i].exp_flush});
            chk($sformatf("vec%0d new_pc", i), new_pc, vecs[i].exp_newpc);
            chk($sformatf("vec%0d delayslot", i), {31'b0, in_ds}, {31'b0, vecs[i].exp_ds});
            if (vecs[i].exp_flush)
                chk($sformatf("vec%0d inst_addr", i), inst_addr, vecs[i].pc);
            drain();
        end

        // Syscall held steady: one-cycle pulse, two flush cycles, then re-taken
        syscall_in();
        tick();
        chk("sys pulse", excepttype, 32'h08);
        chk("sys flush1", {31'b0, flush}, 32'd1);
        tick();
        chk("sys pulse ends", excepttype, NONE);
        chk("sys flush2", {31'b0, flush}, 32'd1);
        chk("sys new_pc held", new_pc, 32'h8000_0180);
        tick();
        chk("sys flush drop", {31'b0, flush}, 32'd0);
        chk("sys no re-entry", excepttype, NONE);
        tick();
        chk("sys retaken", excepttype, 32'h08);
        drain();

        // Back-to-back RI: only the first is taken
        quiet();
        mem_valid = 1; mem_exc = 10'h010; mem_pc = 32'h8000_5000; ebase = 32'h8000_0000;
        tick();
        chk("b2b first", excepttype, 32'h0a);
        mem_pc = 32'h8000_5004;
        tick();
        chk("b2b second dropped", excepttype, NONE);
        chk("b2b addr kept", inst_addr, 32'h8000_5000);
        drain();

        // Bubble with pending interrupt, then a real instruction
        quiet();
        status = 32'h401; cause = 32'h400; mem_pc = 32'h8000_6000;
        tick();
        chk("bubble no event", {31'b0, flush}, 32'd0);
        mem_valid = 1;
        tick();
        chk("bubble then int", excepttype, 32'h00);
        drain();

        // Reset in the second flush cycle, then a normal syscall
        syscall_in();
        tick();
        quiet();
        tick();
        chk("pre-reset flush", {31'b0, flush}, 32'd1);
        rst = 1;
        tick();
        chk("mid-flush reset flush", {31'b0, flush}, 32'd0);
        chk("mid-flush reset type", excepttype, NONE);
        chk("mid-flush reset new_pc", new_pc, 32'd0);
        rst = 0;
        syscall_in();
        tick();
        chk("post-reset syscall", excepttype, 32'h08);
        chk("post-reset new_pc", new_pc, 32'h8000_0180);
        drain();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [9:0] e;
            rst       = ($urandom_range(0, 199) == 0);
            mem_valid = ($urandom_range(0, 3) != 0);
            e = '0;
            for (int b = 0; b < 10; b++) e[b] = ($urandom_range(0, 11) == 0);
            mem_exc  = e;
            mem_pc   = $urandom;
            mem_ds   = 1'($urandom_range(0, 1));
            status   = {16'h0, 8'($urandom), 6'h0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1))};
            cause    = {16'h0, 8'($urandom_range(0, 3) == 0 ? $urandom : 0), 8'h0};
            epc      = $urandom;
            ebase    = $urandom;
            wb_we    = ($urandom_range(0, 2) == 0);
            wb_waddr = 5'(addrs[$urandom_range(0, 3)]);
            wb_wdata = $urandom;
            tick();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
